// File: rtl/comp_a2_serial.sv
`default_nettype none
// ============================================================================
//  Module   : comp_a2_serial
//  Brief    : Bit-serial two's-complement negator, LSB-first, one bit per
//             clock, valid/ready on both sides, overflow and zero flags.
//             Optional absolute-value mode enabled by COMP_A2_SERIAL_ABS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module comp_a2_serial #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef COMP_A2_SERIAL_ABS_EN
    input  logic             abs_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);

    localparam logic [1:0]       c_st_idle  = 2'd0;
    localparam logic [1:0]       c_st_shift = 2'd1;
    localparam logic [1:0]       c_st_done  = 2'd2;
    localparam logic [CNT_W-1:0] c_last     = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_seen;
    logic             r_ovf;
    logic             r_zero;
    logic             w_accept;
    logic             w_consume;
    logic             w_last;
    logic             w_bit;
    logic             w_inv;
    logic             w_res_bit;

    assign w_last    = (r_cnt == c_last);
    assign w_bit     = r_sreg[0];
    assign w_res_bit = w_bit ^ w_inv;

`ifdef COMP_A2_SERIAL_ABS_EN
    // Set when a non-negative operand arrives in abs mode: copy every bit.
    logic r_pass;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass <= 1'b0;
        end else if (w_accept) begin
            r_pass <= abs_mode & ~in_data[WIDTH-1];
        end
    end

    assign w_inv = r_seen & ~r_pass;
`else
    assign w_inv = r_seen;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            c_st_idle: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) begin
                    w_state_nxt = c_st_shift;
                end
            end
            c_st_shift: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                w_consume = out_ready;
                if (out_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Datapath: the result register fills from the top so that after WIDTH
    // shifts the first-processed bit sits at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_seen <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sreg <= in_data;
                r_cnt  <= '0;
                r_seen <= 1'b0;
            end
            if (r_state == c_st_shift) begin
                r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
                r_res  <= {w_res_bit, r_res[WIDTH-1:1]};
                r_seen <= r_seen | w_bit;
                r_cnt  <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    // Last bit is the MSB: a lone 1 there is the most negative value.
                    r_ovf  <= w_bit & ~r_seen;
                    r_zero <= ~(r_seen | w_bit);
                end
            end
            if (w_consume) begin
                r_ovf  <= 1'b0;
                r_zero <= 1'b0;
            end
        end
    end

    assign out_data = r_res;
    assign ovf      = r_ovf;
    assign zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_comp_a2_serial.sv
`default_nettype none
// ============================================================================
//  Module   : tb_comp_a2_serial
//  Brief    : Scoreboard bench for comp_a2_serial at WIDTH=4 and WIDTH=8;
//             abs-mode cases run when COMP_A2_SERIAL_ABS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_comp_a2_serial;

    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iv4 = 1'b0, ir4, ov4, ordy4 = 1'b1, ovf4, z4, busy4, abs4 = 1'b0;
    logic [3:0] id4 = '0, od4;
    logic       iv8 = 1'b0, ir8, ov8, ordy8 = 1'b1, ovf8, z8, busy8;
    logic [7:0] id8 = '0, od8;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    bit   pend[2];
    int   k[2];
    logic [31:0] exp_od[2];
    int   cyc = 0;
    int   last_acc = -1;
    bit   int_chk = 1'b0;
    bit   rdy_rand = 1'b0;

    always #5 clk = ~clk;

    comp_a2_serial #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .in_data   (id4),
`ifdef COMP_A2_SERIAL_ABS_EN
        .abs_mode  (abs4),
`endif
        .out_valid (ov4),
        .out_ready (ordy4),
        .out_data  (od4),
        .ovf       (ovf4),
        .zero      (z4),
        .busy      (busy4)
    );

    comp_a2_serial #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .in_data   (id8),
`ifdef COMP_A2_SERIAL_ABS_EN
        .abs_mode  (1'b0),
`endif
        .out_valid (ov8),
        .out_ready (ordy8),
        .out_data  (od8),
        .ovf       (ovf8),
        .zero      (z8),
        .busy      (busy8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int w, input logic [31:0] x, input logic a);
        exp_t        m;
        logic [31:0] mask;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        m.zero = (x == 32'd0);
        if (a && !x[w-1]) begin
            m.data = x;
            m.ovf  = 1'b0;
        end else begin
            m.data = (~x + 32'd1) & mask;
            m.ovf  = (x == (32'd1 << (w - 1)));
        end
        return m;
    endfunction

    // Per-DUT expected handshake model plus scoreboard, evaluated each negedge.
    task automatic mon(input int d, input int w, input logic iv, input logic ir,
                       input logic ov, input logic ordy, input logic busy,
                       input logic [31:0] od, input logic ovf, input logic zero,
                       input logic [31:0] id, input logic a);
        exp_t  e;
        bit    exp_ov, acc, hs, empty;
        string p;
        p = (d == 0) ? "w4" : "w8";
        if (rst) begin
            pend[d]   = 1'b0;
            k[d]      = 0;
            exp_od[d] = '0;
            if (d == 0) sb0.delete(); else sb1.delete();
            return;
        end
        exp_ov = pend[d] && (k[d] > w);
        check({p, "_in_ready"}, ir, !pend[d]);
        check({p, "_busy"}, busy, pend[d]);
        check({p, "_out_valid"}, ov, exp_ov);
        if (!pend[d]) begin
            check({p, "_idle_data"}, od, exp_od[d]);
            check({p, "_idle_ovf"}, ovf, 1'b0);
            check({p, "_idle_zero"}, zero, 1'b0);
        end
        if (exp_ov) begin
            empty = (d == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
            if (empty) begin
                check({p, "_sb_empty"}, ov, 1'b0);
            end else begin
                e = (d == 0) ? sb0[0] : sb1[0];
                check({p, "_out_data"}, od, e.data);
                check({p, "_ovf"}, ovf, e.ovf);
                check({p, "_zero"}, zero, e.zero);
                if (ordy) begin
                    if (d == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
                    exp_od[d] = e.data;
                end
            end
        end
        acc = iv && !pend[d];
        hs  = exp_ov && ordy;
        if (hs) pend[d] = 1'b0;
        if (acc) begin
            if (d == 0) sb0.push_back(model(w, id, a)); else sb1.push_back(model(w, id, a));
            pend[d] = 1'b1;
            k[d]    = 1;
            if (d == 1 && int_chk) begin
                if (last_acc >= 0) check("w8_interval", cyc - last_acc, 10);
                last_acc = cyc;
            end
        end else if (pend[d] && k[d] <= w) begin
            k[d]++;
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0, 4, iv4, ir4, ov4, ordy4, busy4, {28'b0, od4}, ovf4, z4, {28'b0, id4}, abs4);
        mon(1, 8, iv8, ir8, ov8, ordy8, busy8, {24'b0, od8}, ovf8, z8, {24'b0, id8}, 1'b0);
    end

    always @(posedge clk) begin
        #1;
        ordy4 = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send4(input logic [3:0] x, input logic a);
        bit got = 1'b0;
        iv4 = 1'b1; id4 = x; abs4 = a;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ir4 === 1'b1) begin got = 1'b1; break; end
        end
        @(posedge clk); #1;
        iv4 = 1'b0; id4 = 4'($urandom); abs4 = 1'b0;
        if (!got) check("w4_accept_timeout", ir4, 1'b1);
    endtask

    task automatic send8(input logic [7:0] x);
        bit got = 1'b0;
        iv8 = 1'b1; id8 = x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ir8 === 1'b1) begin got = 1'b1; break; end
        end
        @(posedge clk); #1;
        if (!got) check("w8_accept_timeout", ir8, 1'b1);
    endtask

    task automatic wait_done(input int d);
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (!pend[d]) begin done = 1'b1; break; end
        end
        #1;
        if (!done) check((d == 0) ? "w4_done_timeout" : "w8_done_timeout",
                         (d == 0) ? busy4 : busy8, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        send4(4'b0011, 1'b0); wait_done(0);
        send4(4'b1000, 1'b0); wait_done(0);
        send4(4'b0000, 1'b0); wait_done(0);
        send4(4'b1111, 1'b0); wait_done(0);

        // Abort in the second shift cycle, then a fresh word.
        send4(4'b1111, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        send4(4'b0101, 1'b0); wait_done(0);

        rdy_rand = 1'b1;
        for (int i = 0; i < 12; i++) send4(4'($urandom), 1'b0);
        wait_done(0);
        rdy_rand = 1'b0;
        wait_done(0);

`ifdef COMP_A2_SERIAL_ABS_EN
        send4(4'b0110, 1'b1); wait_done(0);
        send4(4'b1010, 1'b1); wait_done(0);
        send4(4'b1000, 1'b1); wait_done(0);
        send4(4'b0000, 1'b1); wait_done(0);
        send4(4'b0110, 1'b0); wait_done(0);
`endif

        // Back-to-back exhaustive sweep with in_valid held high.
        last_acc = -1;
        int_chk  = 1'b1;
        iv8      = 1'b1;
        for (int x = 0; x < 256; x++) begin
            bit got = 1'b0;
            id8 = 8'(x);
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (ir8 === 1'b1) begin got = 1'b1; break; end
            end
            @(posedge clk); #1;
            if (!got) check("w8_sweep_timeout", ir8, 1'b1);
        end
        iv8     = 1'b0;
        int_chk = 1'b0;
        wait_done(1);

        // Stall: result must hold while out_ready is low.
        ordy8 = 1'b0;
        send8(8'hFF);
        iv8 = 1'b0; id8 = 8'h5A;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            if (ov8) break;
        end
        repeat (20) @(posedge clk);
        #1 ordy8 = 1'b1;
        wait_done(1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
